i2c_target_responder: RTL

- Synthesizable I2C target (slave) endpoint; the responding end of the bus driven by the I2CMB master.
- Sits on the external SCL/SDA pins beside the DUT bus. Decodes START/STOP/address/data, ACKs its own address, delivers written bytes, and fetches read bytes through a simple request port.
- Direction bit encoding matches the package op type: 0 = I2_WRITE, 1 = I2_READ.

---
 rtl/i2c_target_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_responder.sv
// I2C target endpoint: ACKs TGT_ADDR, delivers written bytes, fetches read bytes via rd_req/rd_data.
// SCL/SDA are synchronized; all bus events are acted on the clk after synchronized detection.
module i2c_target_responder #(
  parameter logic [6:0] TGT_ADDR    = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       busy,
  output logic       op,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   byte_done_q, byte_done_d;
  logic                   sda_o_q, sda_o_d;
  logic                   busy_q, busy_d;
  logic                   op_q, op_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   rd_req_q, rd_req_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   nack_q, nack_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] shift_in;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SCL must be steadily high across the SDA edge; a simultaneous change is data.
  assign start_cond = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_cond  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign shift_in   = {shift_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      byte_done_q <= 1'b0;
      sda_o_q     <= 1'b1;
      busy_q      <= 1'b0;
      op_q        <= 1'b0;
      wr_data_q   <= 8'h00;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      byte_done_q <= byte_done_d;
      sda_o_q     <= sda_o_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      rd_req_q    <= rd_req_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      nack_q      <= nack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    byte_done_d = byte_done_q;
    sda_o_d     = sda_o_q;
    busy_d      = busy_q;
    op_d        = op_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    nack_d      = 1'b0;

    if (start_cond) begin
      start_d     = 1'b1;
      state_d     = ADDR;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
      sda_o_d     = 1'b1;
    end else if (stop_cond) begin
      stop_d      = 1'b1;
      state_d     = IDLE;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_in[7:1] == TGT_ADDR) begin
                op_d    = shift_in[0];
                busy_d  = 1'b1;
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          // sda_o itself marks the phase: released = ACK not yet driven.
          if (scl_fall) begin
            if (sda_o_q) begin
              sda_o_d = 1'b0;
            end else begin
              sda_o_d = 1'b1;
              if (op_q) begin
                state_d  = RD_BYTE;
                rd_req_d = 1'b1;
              end else begin
                state_d = WR_BYTE;
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            wr_data_d   = shift_q;
            wr_valid_d  = 1'b1;
            sda_o_d     = 1'b0;
            byte_done_d = 1'b0;
            state_d     = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_o_d = 1'b1;
            state_d = WR_BYTE;
          end
        end
        RD_BYTE: begin
          // The cycle rd_req is visible is the load cycle; MSB goes out immediately.
          if (rd_req_q) begin
            shift_d = rd_data;
            sda_o_d = rd_data[7];
            cnt_d   = 3'd0;
          end else if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_o_d = 1'b1;
              cnt_d   = 3'd0;
              state_d = RD_ACK;
            end else begin
              cnt_d   = cnt_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              sda_o_d = shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_s) begin
            nack_d  = 1'b1;
            state_d = IGNORE;
          end else if (scl_fall) begin
            state_d  = RD_BYTE;
            rd_req_d = 1'b1;
          end
        end
        IGNORE:  sda_o_d = 1'b1;
        IDLE:    sda_o_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_o     = sda_o_q;
  assign busy      = busy_q;
  assign op        = op_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign rd_req    = rd_req_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign nack_det  = nack_q;

endmodule
